ping_sensor_emu: RTL and testbench

//  Cycle-accurate emulator of a PING-style ultrasonic sensor: the responder end of
//  the single-wire trigger/echo protocol. It watches the trigger pulse from the

---
 rtl/ping_sensor_emu.sv | 157 +++++++++++++++
 tb/tb_ping_sensor_emu.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ping_sensor_emu.sv
// PING-style ultrasonic sensor emulator: answers a trigger pulse on the
// shared SIG line with a hold-off and an echo pulse of programmed width.
module ping_sensor_emu #(
   parameter int unsigned US_CYC       = 100,
   parameter int unsigned TRIG_MIN_CYC = 200,
   parameter int unsigned HOLDOFF_US   = 750,
   parameter int unsigned ECHO_MIN_US  = 115,
   parameter int unsigned ECHO_MAX_US  = 18500,
   parameter int unsigned RECOVER_US   = 200
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sig_in,
   input  logic [14:0] echo_us,
   output logic        sig_out,
   output logic        sig_oe,
   output logic        busy,
   output logic        done,
   output logic        short_trig,
   output logic [7:0]  meas_cnt
);

   localparam int unsigned PW = (US_CYC > 1) ? $clog2(US_CYC) : 1;

   localparam logic [PW-1:0] PRE_LAST  = PW'(US_CYC - 1);
   localparam logic [15:0]   TRIG_MIN  = 16'(TRIG_MIN_CYC);
   localparam logic [14:0]   HOLD_LAST = 15'(HOLDOFF_US - 1);
   localparam logic [14:0]   REC_LAST  = 15'(RECOVER_US - 1);
   localparam logic [14:0]   E_MIN     = 15'(ECHO_MIN_US);
   localparam logic [14:0]   E_MAX     = 15'(ECHO_MAX_US);

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      HOLDOFF,
      ECHO,
      RECOVER
   } state_t;

   state_t        state_q;
   logic          s1_q, s_q, sd_q;
   logic [PW-1:0] pre_q;
   logic [14:0]   us_q;
   logic [15:0]   trig_q;
   logic [14:0]   echo_w_q;
   logic [14:0]   echo_d;
   logic          out_q, oe_q, busy_q, done_q, short_q;
   logic [7:0]    meas_q;
   logic          tick;

   assign tick = (pre_q == PRE_LAST);

   always_comb begin
      echo_d = echo_us;
      if (echo_us < E_MIN) echo_d = E_MIN;
      else if (echo_us > E_MAX) echo_d = E_MAX;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         s1_q     <= 1'b0;
         s_q      <= 1'b0;
         sd_q     <= 1'b0;
         pre_q    <= '0;
         us_q     <= '0;
         trig_q   <= '0;
         echo_w_q <= '0;
         out_q    <= 1'b0;
         oe_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         short_q  <= 1'b0;
         meas_q   <= '0;
      end else begin
         s1_q    <= sig_in;
         s_q     <= s1_q;
         sd_q    <= s_q;
         done_q  <= 1'b0;
         short_q <= 1'b0;
         pre_q   <= tick ? '0 : pre_q + 1'b1;
         unique case (state_q)
            IDLE: begin
               if (s_q && !sd_q) begin
                  state_q <= TRIG;
                  trig_q  <= 16'd1;
                  busy_q  <= 1'b1;
                  pre_q   <= '0;
               end
            end
            TRIG: begin
               if (s_q) begin
                  if (trig_q != 16'hFFFF) trig_q <= trig_q + 16'd1;
               end else if (trig_q >= TRIG_MIN) begin
                  state_q  <= HOLDOFF;
                  echo_w_q <= echo_d;
                  oe_q     <= 1'b1;
                  out_q    <= 1'b0;
                  us_q     <= '0;
                  pre_q    <= '0;
               end else begin
                  state_q <= IDLE;
                  short_q <= 1'b1;
                  busy_q  <= 1'b0;
                  pre_q   <= '0;
               end
            end
            HOLDOFF: begin
               if (tick) begin
                  if (us_q == HOLD_LAST) begin
                     state_q <= ECHO;
                     out_q   <= 1'b1;
                     us_q    <= '0;
                  end else begin
                     us_q <= us_q + 15'd1;
                  end
               end
            end
            ECHO: begin
               if (tick) begin
                  if (us_q == echo_w_q - 15'd1) begin
                     state_q <= RECOVER;
                     out_q   <= 1'b0;
                     oe_q    <= 1'b0;
                     done_q  <= 1'b1;
                     meas_q  <= meas_q + 8'd1;
                     us_q    <= '0;
                  end else begin
                     us_q <= us_q + 15'd1;
                  end
               end
            end
            RECOVER: begin
               // Input is ignored here; IDLE needs a fresh edge.
               if (tick) begin
                  if (us_q == REC_LAST) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     us_q    <= '0;
                  end else begin
                     us_q <= us_q + 15'd1;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign sig_out    = out_q;
   assign sig_oe     = oe_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign short_trig = short_q;
   assign meas_cnt   = meas_q;

endmodule

// File: tb/tb_ping_sensor_emu.sv
// Bench for ping_sensor_emu: vector table of trigger/echo cases plus
// hand sequences for reset, mid-echo reset and counter wrap.
module tb_ping_sensor_emu;

   logic        clk;
   logic        reset;
   logic        sig_in;
   logic [14:0] echo_us;
   logic        sig_out;
   logic        sig_oe;
   logic        busy;
   logic        done;
   logic        short_trig;
   logic [7:0]  meas_cnt;

   int pass_cnt;
   int total_cnt;

   ping_sensor_emu #(
      .US_CYC       (4),
      .TRIG_MIN_CYC (8),
      .HOLDOFF_US   (3),
      .ECHO_MIN_US  (2),
      .ECHO_MAX_US  (20),
      .RECOVER_US   (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sig_in     (sig_in),
      .echo_us    (echo_us),
      .sig_out    (sig_out),
      .sig_oe     (sig_oe),
      .busy       (busy),
      .done       (done),
      .short_trig (short_trig),
      .meas_cnt   (meas_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int trig;
      int echo;
      int chg_at;
      int chg_val;
      bit rec_pulse;
      int e_short;
      int e_hold;
      int e_echo;
      int e_done;
      int e_rec;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      logic [7:0] m0;
      logic [7:0] dm;
      int hold, ech, dn, sh, rec, pul;
      bit seen_done;
      hold = 0; ech = 0; dn = 0; sh = 0; rec = 0; pul = 0;
      seen_done = 1'b0;
      echo_us = 15'(v.echo);
      m0 = meas_cnt;
      sig_in = 1'b1;
      repeat (v.trig) @(negedge clk);
      sig_in = 1'b0;
      for (int i = 0; i < 160; i++) begin
         @(negedge clk);
         if (sig_oe && !sig_out) hold++;
         if (sig_oe && sig_out) ech++;
         if (short_trig) sh++;
         if (done) begin
            dn++;
            seen_done = 1'b1;
            if (v.rec_pulse) pul = 10;
         end
         if (seen_done && busy && !sig_oe) rec++;
         if (i == v.chg_at) echo_us = 15'(v.chg_val);
         if (pul > 0) begin
            sig_in = 1'b1;
            pul--;
         end else begin
            sig_in = 1'b0;
         end
      end
      dm = meas_cnt - m0;
      chk($sformatf("v%0d short_trig", idx), sh, v.e_short);
      chk($sformatf("v%0d holdoff", idx), hold, v.e_hold);
      chk($sformatf("v%0d echo", idx), ech, v.e_echo);
      chk($sformatf("v%0d done", idx), dn, v.e_done);
      chk($sformatf("v%0d recover", idx), rec, v.e_rec);
      chk($sformatf("v%0d meas_inc", idx), int'(dm), v.e_done);
      chk($sformatf("v%0d busy_end", idx), int'(busy), 0);
   endtask

   initial begin
      int dn, cnt, oe_cnt;
      bit to;
      pass_cnt  = 0;
      total_cnt = 0;
      reset   = 1'b1;
      sig_in  = 1'b0;
      echo_us = 15'd5;

      vecs[0] = '{10, 5,   -1, 0,  0, 0, 12, 20, 1, 8};
      vecs[1] = '{5,  5,   -1, 0,  0, 1, 0,  0,  0, 0};
      vecs[2] = '{10, 0,   -1, 0,  0, 0, 12, 8,  1, 8};
      vecs[3] = '{10, 100, -1, 0,  0, 0, 12, 80, 1, 8};
      vecs[4] = '{8,  1,   -1, 0,  0, 0, 12, 8,  1, 8};
      vecs[5] = '{7,  9,   -1, 0,  0, 1, 0,  0,  0, 0};
      vecs[6] = '{10, 20,  -1, 0,  0, 0, 12, 80, 1, 8};
      vecs[7] = '{10, 21,  -1, 0,  0, 0, 12, 80, 1, 8};
      vecs[8] = '{10, 3,   6,  15, 0, 0, 12, 12, 1, 8};
      vecs[9] = '{12, 4,   -1, 0,  1, 0, 12, 16, 1, 8};

      // Reset held while the line toggles.
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         sig_in = ~sig_in;
      end
      #1;
      chk("rst sig_out", int'(sig_out), 0);
      chk("rst sig_oe", int'(sig_oe), 0);
      chk("rst busy", int'(busy), 0);
      chk("rst done", int'(done), 0);
      chk("rst short", int'(short_trig), 0);
      chk("rst meas", int'(meas_cnt), 0);
      @(negedge clk);
      sig_in = 1'b0;
      repeat (4) @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

      // Reset in the middle of an echo.
      echo_us = 15'd10;
      sig_in = 1'b1;
      repeat (10) @(negedge clk);
      sig_in = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (sig_out) begin
            to = 1'b0;
            break;
         end
      end
      chk("mid echo reached", int'(to), 0);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("mid rst sig_oe", int'(sig_oe), 0);
      chk("mid rst sig_out", int'(sig_out), 0);
      chk("mid rst done", int'(done), 0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      dn = 0;
      oe_cnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done) dn++;
         if (sig_oe) oe_cnt++;
      end
      chk("mid rst no done", dn, 0);
      chk("mid rst no oe", oe_cnt, 0);
      chk("mid rst meas", int'(meas_cnt), 0);

      // 256 back-to-back measurements wrap the counter.
      echo_us = 15'd0;
      dn = 0;
      to = 1'b0;
      for (int k = 0; k < 256; k++) begin
         sig_in = 1'b1;
         repeat (8) @(negedge clk);
         sig_in = 1'b0;
         cnt = 0;
         do begin
            @(negedge clk);
            if (done) dn++;
            cnt++;
         end while (busy && cnt < 200);
         if (cnt >= 200) to = 1'b1;
         if (k == 254) chk("wrap meas 255", int'(meas_cnt), 255);
      end
      chk("wrap timeout", int'(to), 0);
      chk("wrap done pulses", dn, 256);
      chk("wrap meas 0", int'(meas_cnt), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
